// File: rtl/antares_dport_scratchpad_pkg.sv
// ---------------------------------------------------------------------------
// antares_dport_scratchpad_pkg
//   Shared definitions for the dport scratchpad responder: the three-state
//   request FSM encoding, the read/write strobe codes seen on the wr bus and
//   a small helper to classify a request as a write.
// ---------------------------------------------------------------------------
package antares_dport_scratchpad_pkg;

    // Request FSM: a request is captured in IDLE, optionally ages in WAIT
    // to emulate a slow memory, and completes in RESP.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Byte-strobe codes on the wr bus; all-zero means a read.
    localparam logic [3:0] WR_READ = 4'b0000;
    localparam logic [3:0] WR_WORD = 4'b1111;

    // Width of the wait-state counter (WAIT_STATES is limited to 0..15).
    localparam int WAIT_CNT_W = 4;

    // Any set strobe makes the request a write.
    function automatic logic isWriteReq(input logic [3:0] wrStrobe);
        return wrStrobe != WR_READ;
    endfunction

endpackage

// File: rtl/antares_spad_ram.sv
// ---------------------------------------------------------------------------
// antares_spad_ram
//   Single-port word RAM for the scratchpad: 2**ADDR_WIDTH words of 32 bits,
//   four independent byte-lane write enables and a registered (synchronous)
//   read port. Contents are never reset.
//
// Ports
//   clk_i    in   1            clock, rising edge
//   addr_i   in   ADDR_WIDTH   word address shared by read and write
//   we_i     in   4            byte-lane write enables, [0] = bits [7:0]
//   wdata_i  in   32           write data
//   re_i     in   1            read enable; rdata_o updates on the next edge
//   rdata_o  out  32           registered read data, held until the next read
// ---------------------------------------------------------------------------
module antares_spad_ram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [3:0]            we_i,
    input  logic [31:0]           wdata_i,
    input  logic                  re_i,
    output logic [31:0]           rdata_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Byte-lane writes and the synchronous read share one address. The read
    // register holds its value between reads so the top can present it for
    // the whole response cycle.
    always_ff @(posedge clk_i) begin
        for (int lane = 0; lane < 4; lane++) begin
            if (we_i[lane]) begin
                mem_q[addr_i][lane*8 +: 8] <= wdata_i[lane*8 +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/antares_dport_scratchpad.sv
// ---------------------------------------------------------------------------
// antares_dport_scratchpad
//   Responder end of the core's dport bus: a word-organised scratchpad RAM
//   that answers address/enable/wr/data requests with a one-cycle ready pulse
//   after WAIT_STATES programmable wait cycles. Accesses outside the mapped
//   window complete with error=1 instead of hanging the initiator.
//
// Ports
//   clk       in   1    core clock, rising edge
//   rst       in   1    synchronous active-high reset (RAM contents kept)
//   address   in   32   byte address, bits [1:0] ignored
//   data_i    in   32   write data
//   wr        in   4    byte write strobes, 4'b0000 = read
//   enable    in   1    request valid, held with its fields until ready
//   data_o    out  32   read data, valid with ready on an in-window read
//   ready     out  1    one-cycle completion pulse
//   error     out  1    out-of-window completion, only together with ready
//   err_valid out  1    (ANTARES_DPORT_SPAD_ERRCAP_EN only) sticky error flag
//   err_addr  out  32   (ANTARES_DPORT_SPAD_ERRCAP_EN only) first error address
//
// Configuration
//   ANTARES_DPORT_SPAD_ERRCAP_EN: when defined, the first out-of-window
//   address is latched into err_addr and err_valid is set until reset.
// ---------------------------------------------------------------------------
module antares_dport_scratchpad
    import antares_dport_scratchpad_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] data_i,
    input  logic [3:0]  wr,
    input  logic        enable,
    output logic [31:0] data_o,
    output logic        ready,
    output logic        error
`ifdef ANTARES_DPORT_SPAD_ERRCAP_EN
    ,
    output logic        err_valid,
    output logic [31:0] err_addr
`endif
);

    // Window size in bytes, kept 33 bits wide so a window covering the whole
    // 32-bit space does not wrap to zero.
    localparam logic [32:0] WINDOW_BYTES = 33'd4 << ADDR_WIDTH;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   waitCnt_q, waitCnt_d;
    logic                    captureEn;

    logic [ADDR_WIDTH-1:0]   wordIdx_q;
    logic [3:0]              wr_q;
    logic [31:0]             wdata_q;
    logic                    inWin_q;

    logic                    ready_q;
    logic                    error_q;
    logic                    readResp_q;

    logic [31:0]             busOffset;
    logic                    busInWin;
    logic [ADDR_WIDTH-1:0]   busWordIdx;

    logic [ADDR_WIDTH-1:0]   effWordIdx;
    logic [3:0]              effWr;
    logic                    effInWin;
    logic                    respNext;

    logic [3:0]              ramWe;
    logic                    ramRe;
    logic [31:0]             ramRdata;

    // Window check on the live bus. Subtracting the base and comparing
    // unsigned also rejects addresses below the base, since they wrap high.
    // The base is window-aligned, so the low offset bits give the word index.
    always_comb begin
        busOffset  = address - BASE_ADDR;
        busInWin   = {1'b0, busOffset} < WINDOW_BYTES;
        busWordIdx = busOffset[ADDR_WIDTH+1:2];
    end

    // While idle the request is still on the bus (and may go straight to
    // RESP when there are no wait states), so use the bus fields; after
    // capture use the registered copies so bus changes are ignored.
    always_comb begin
        if (state_q == ST_IDLE) begin
            effWordIdx = busWordIdx;
            effWr      = wr;
            effInWin   = busInWin;
        end else begin
            effWordIdx = wordIdx_q;
            effWr      = wr_q;
            effInWin   = inWin_q;
        end
    end

    // Next-state logic: IDLE captures on enable, WAIT counts the loaded
    // value down to zero, RESP always returns to IDLE so the following
    // idle cycle can sample the next request.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        captureEn = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    captureEn = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_d   = ST_WAIT;
                        waitCnt_d = WAIT_LOAD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (waitCnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    waitCnt_d = waitCnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // RAM control. The read is issued on the edge that enters RESP so the
    // RAM output register is valid for the whole RESP cycle. Writes commit
    // on the edge that leaves RESP; reset suppresses both, so an aborted
    // write never reaches the array.
    always_comb begin
        respNext = (state_d == ST_RESP);
        ramRe    = !rst && respNext && effInWin && !isWriteReq(effWr);
        if (!rst && state_q == ST_RESP && inWin_q) begin
            ramWe = wr_q;
        end else begin
            ramWe = WR_READ;
        end
    end

    antares_spad_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i   (clk),
        .addr_i  (effWordIdx),
        .we_i    (ramWe),
        .wdata_i (wdata_q),
        .re_i    (ramRe),
        .rdata_o (ramRdata)
    );

    // State, counter, captured request and registered response flags.
    // ready/error/readResp are all set from the entry into RESP, so error
    // can only ever be high in the same cycle as ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            waitCnt_q  <= '0;
            wordIdx_q  <= '0;
            wr_q       <= WR_READ;
            wdata_q    <= '0;
            inWin_q    <= 1'b0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
            readResp_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            if (captureEn) begin
                wordIdx_q <= busWordIdx;
                wr_q      <= wr;
                wdata_q   <= data_i;
                inWin_q   <= busInWin;
            end
            ready_q    <= respNext;
            error_q    <= respNext && !effInWin;
            readResp_q <= respNext && effInWin && !isWriteReq(effWr);
        end
    end

    // Read data is shown only on an in-window read response; writes and
    // error responses return zero.
    assign data_o = readResp_q ? ramRdata : 32'h0;
    assign ready  = ready_q;
    assign error  = error_q;

`ifdef ANTARES_DPORT_SPAD_ERRCAP_EN
    logic [31:0] addr_q;
    logic        errValid_q;
    logic [31:0] errAddr_q;

    // Keep the full byte address of the request and latch it on the first
    // error response only; later errors leave the record alone until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            errValid_q <= 1'b0;
            errAddr_q  <= '0;
        end else begin
            if (captureEn) begin
                addr_q <= address;
            end
            if (state_q == ST_RESP && !inWin_q && !errValid_q) begin
                errValid_q <= 1'b1;
                errAddr_q  <= addr_q;
            end
        end
    end

    assign err_valid = errValid_q;
    assign err_addr  = errAddr_q;
`endif

endmodule

// File: tb/tb_antares_dport_scratchpad.sv
// ---------------------------------------------------------------------------
// tb_antares_dport_scratchpad
//   Drives three scratchpad instances (WAIT_STATES = 0, 1 and 3) sharing one
//   clock and reset. Expected responses are queued when a request is driven
//   and compared when ready appears.
// ---------------------------------------------------------------------------
module tb_antares_dport_scratchpad;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wr;
        logic [31:0] expData;
        logic        expErr;
    } vec_t;

    logic              clk;
    logic              rst;
    logic [2:0]        en;
    logic [2:0][31:0]  addrV;
    logic [2:0][31:0]  wdV;
    logic [2:0][3:0]   wrV;
    logic [2:0][31:0]  doV;
    logic [2:0]        rdy;
    logic [2:0]        errV;
`ifdef ANTARES_DPORT_SPAD_ERRCAP_EN
    logic [2:0]        errValidV;
    logic [2:0][31:0]  errAddrV;
`endif

    exp_t sb[$];
    vec_t vecs[$];
    int   vecCount  = 0;
    int   missCount = 0;

    // Index 0: no wait states, 1: one wait state, 2: three wait states.
    antares_dport_scratchpad #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .address(addrV[0]), .data_i(wdV[0]), .wr(wrV[0]),
        .enable(en[0]), .data_o(doV[0]), .ready(rdy[0]), .error(errV[0])
`ifdef ANTARES_DPORT_SPAD_ERRCAP_EN
        , .err_valid(errValidV[0]), .err_addr(errAddrV[0])
`endif
    );

    antares_dport_scratchpad #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(1)) dut1 (
        .clk(clk), .rst(rst), .address(addrV[1]), .data_i(wdV[1]), .wr(wrV[1]),
        .enable(en[1]), .data_o(doV[1]), .ready(rdy[1]), .error(errV[1])
`ifdef ANTARES_DPORT_SPAD_ERRCAP_EN
        , .err_valid(errValidV[1]), .err_addr(errAddrV[1])
`endif
    );

    antares_dport_scratchpad #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst), .address(addrV[2]), .data_i(wdV[2]), .wr(wrV[2]),
        .enable(en[2]), .data_o(doV[2]), .ready(rdy[2]), .error(errV[2])
`ifdef ANTARES_DPORT_SPAD_ERRCAP_EN
        , .err_valid(errValidV[2]), .err_addr(errAddrV[2])
`endif
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something waits forever.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int latOf(input int k);
        if (k == 0) return 0;
        if (k == 1) return 1;
        return 3;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with the instance's response.
    task automatic checkOutput(input int k, input string name);
        exp_t e;
        if (sb.size() == 0) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL %s scoreboard: got empty queue, required an entry", name);
        end else begin
            e = sb.pop_front();
            checkValue({name, " data"}, doV[k], e.data);
            checkValue({name, " error"}, {31'b0, errV[k]}, {31'b0, e.err});
        end
    endtask

    // One complete transaction; called and returns at a falling edge.
    task automatic applyStimulus(input int k, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wrS, input logic [31:0] expData,
                                 input logic expErr, input string name);
        int cycles;
        bit got;
        exp_t e;
        e.data = expData;
        e.err  = expErr;
        sb.push_back(e);
        en[k]    = 1'b1;
        addrV[k] = addr;
        wdV[k]   = wdata;
        wrV[k]   = wrS;
        @(posedge clk);
        cycles = 0;
        got    = 1'b0;
        while (cycles < 20 && !got) begin
            @(negedge clk);
            cycles++;
            if (rdy[k]) got = 1'b1;
        end
        if (!got) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL %s timeout: got no ready in 20 cycles, required ready", name);
            void'(sb.pop_front());
        end else begin
            checkValue({name, " latency"}, 32'(cycles), 32'(1 + latOf(k)));
            checkOutput(k, name);
        end
        en[k]  = 1'b0;
        wrV[k] = 4'h0;
        @(negedge clk);
        checkValue({name, " pulse end"}, {31'b0, rdy[k]}, 32'h0);
    endtask

    initial begin
        bit sawReady;
        exp_t e;

        rst   = 1'b1;
        en    = '0;
        addrV = '0;
        wdV   = '0;
        wrV   = '0;

        // Reset held two cycles with the bus idle, then a few idle cycles.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 1) rst = 1'b0;
            for (int k = 0; k < 3; k++) begin
                checkValue($sformatf("reset/idle ready k%0d c%0d", k, c), {31'b0, rdy[k]}, 32'h0);
                checkValue($sformatf("reset/idle error k%0d c%0d", k, c), {31'b0, errV[k]}, 32'h0);
                checkValue($sformatf("reset/idle data k%0d c%0d", k, c), doV[k], 32'h0);
            end
        end
`ifdef ANTARES_DPORT_SPAD_ERRCAP_EN
        checkValue("reset err_valid", {31'b0, errValidV[1]}, 32'h0);
        checkValue("reset err_addr", errAddrV[1], 32'h0);
`endif

        // Vector table for the one-wait-state instance.
        vecs.push_back('{32'h0000_0010, 32'hDEAD_BEEF, 4'hF,    32'h0,          1'b0});
        vecs.push_back('{32'h0000_0010, 32'h0,         4'h0,    32'hDEAD_BEEF,  1'b0});
        vecs.push_back('{32'h0000_0020, 32'h1122_3344, 4'hF,    32'h0,          1'b0});
        vecs.push_back('{32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 32'h0,          1'b0});
        vecs.push_back('{32'h0000_0020, 32'h0,         4'h0,    32'h11BB_33DD,  1'b0});
        vecs.push_back('{32'h0000_1000, 32'h0,         4'h0,    32'h0,          1'b1});
        vecs.push_back('{32'h0000_2000, 32'h0,         4'h0,    32'h0,          1'b1});
        vecs.push_back('{32'h0000_1010, 32'hFFFF_FFFF, 4'hF,    32'h0,          1'b1});
        vecs.push_back('{32'h0000_0012, 32'h0,         4'h0,    32'hDEAD_BEEF,  1'b0});
        vecs.push_back('{32'h0000_0FFC, 32'h5A5A_A5A5, 4'hF,    32'h0,          1'b0});
        vecs.push_back('{32'h0000_0FFC, 32'h0,         4'h0,    32'h5A5A_A5A5,  1'b0});
        vecs.push_back('{32'hFFFF_FFFC, 32'h0,         4'h0,    32'h0,          1'b1});
        vecs.push_back('{32'h0000_0020, 32'h0,         4'b1000, 32'h0,          1'b0});
        vecs.push_back('{32'h0000_0020, 32'h0,         4'h0,    32'h00BB_33DD,  1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(1, vecs[i].addr, vecs[i].wdata, vecs[i].wr,
                          vecs[i].expData, vecs[i].expErr, $sformatf("vec%0d", i));
        end

`ifdef ANTARES_DPORT_SPAD_ERRCAP_EN
        checkValue("errcap valid", {31'b0, errValidV[1]}, 32'h1);
        checkValue("errcap first addr", errAddrV[1], 32'h0000_1000);
`endif

        // Zero wait states: preload two words, then back-to-back reads with
        // enable held; the address changes during the first response.
        applyStimulus(0, 32'h0, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0, "w0 pre0");
        applyStimulus(0, 32'h4, 32'h1234_5678, 4'hF, 32'h0, 1'b0, "w0 pre4");
        e.data = 32'h0BAD_F00D; e.err = 1'b0; sb.push_back(e);
        e.data = 32'h1234_5678; e.err = 1'b0; sb.push_back(e);
        en[0]    = 1'b1;
        addrV[0] = 32'h0;
        wrV[0]   = 4'h0;
        @(posedge clk);
        @(negedge clk);
        checkValue("b2b first ready", {31'b0, rdy[0]}, 32'h1);
        checkOutput(0, "b2b first");
        addrV[0] = 32'h4;
        @(negedge clk);
        checkValue("b2b gap ready", {31'b0, rdy[0]}, 32'h0);
        @(negedge clk);
        checkValue("b2b second ready", {31'b0, rdy[0]}, 32'h1);
        checkOutput(0, "b2b second");
        en[0] = 1'b0;
        @(negedge clk);
        checkValue("b2b end ready", {31'b0, rdy[0]}, 32'h0);

        // Three wait states: reset during WAIT aborts a pending write.
        applyStimulus(2, 32'h8, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, "w3 pre8");
        en[2]    = 1'b1;
        addrV[2] = 32'h8;
        wdV[2]   = 32'hFFFF_FFFF;
        wrV[2]   = 4'hF;
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b1;
        en[2]  = 1'b0;
        wrV[2] = 4'h0;
        @(negedge clk);
        checkValue("abort ready in reset", {31'b0, rdy[2]}, 32'h0);
        rst = 1'b0;
        sawReady = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rdy[2]) sawReady = 1'b1;
        end
        checkValue("abort no ready", {31'b0, sawReady}, 32'h0);
        applyStimulus(2, 32'h8, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, "abort readback");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
